// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M/RV64M multiply/divide definitions: funct3 op codes, M-extension
// funct7 and the iterative unit's state encoding.
package muldiv_unit_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FAST = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic logic f3_a_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic f3_b_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output flush, in_valid, funct3, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  flush, in_valid, funct3, op_a, op_b, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle over a shared
// 2*XLEN shift register and a single XLEN+1 adder/subtractor.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave mdu_if
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic [XLEN-1:0]   mag_b_q, mag_b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]   mag_a, mag_b, special_res;

   logic [XLEN:0]     add_a, add_b, add_s;
   logic [2*XLEN-1:0] acc_step, prod;
   logic [XLEN-1:0]   quo, rem, final_res;

   // Request decode: signs, magnitudes and RISC-V divide corner cases.
   always_comb begin
      a_neg    = f3_a_signed(mdu_if.funct3) & mdu_if.op_a[XLEN-1];
      b_neg    = f3_b_signed(mdu_if.funct3) & mdu_if.op_b[XLEN-1];
      mag_a    = a_neg ? -mdu_if.op_a : mdu_if.op_a;
      mag_b    = b_neg ? -mdu_if.op_b : mdu_if.op_b;
      div_zero = mdu_if.funct3[2] && (mdu_if.op_b == '0);
      div_ovf  = ((mdu_if.funct3 == F3_DIV) || (mdu_if.funct3 == F3_REM)) &&
                 (mdu_if.op_a == SMIN) && (mdu_if.op_b == '1);
      if (div_zero)
         special_res = mdu_if.funct3[1] ? mdu_if.op_a : '1;
      else
         special_res = mdu_if.funct3[1] ? '0 : mdu_if.op_a;
   end

   // Shared adder: add multiplicand for multiply, trial-subtract divisor for divide.
   always_comb begin
      add_b = {1'b0, mag_b_q};
      if (f3_q[2]) begin
         add_a = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
         add_s = add_a - add_b;
         if (add_s[XLEN])
            acc_step = {acc_q[2*XLEN-2:0], 1'b0};
         else
            acc_step = {add_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         add_a = {1'b0, acc_q[2*XLEN-1:XLEN]};
         add_s = add_a + add_b;
         if (acc_q[0])
            acc_step = {add_s, acc_q[XLEN-1:1]};
         else
            acc_step = {1'b0, acc_q[2*XLEN-1:1]};
      end

      prod = neg_q  ? -acc_step : acc_step;
      quo  = neg_q  ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

      case (f3_q)
         F3_MUL:                     final_res = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:            final_res = quo;
         default:                    final_res = rem;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      mag_b_d  = mag_b_q;
      acc_d    = acc_q;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            if (mdu_if.in_valid && !mdu_if.flush) begin
               f3_d    = mdu_if.funct3;
               neg_d   = a_neg ^ b_neg;
               rneg_d  = a_neg;
               mag_b_d = mag_b;
               cnt_d   = CNT_W'(XLEN - 1);
               if (div_zero || div_ovf) begin
                  state_d = FAST;
                  acc_d   = {{XLEN{1'b0}}, special_res};
               end else begin
                  state_d = CALC;
                  acc_d   = {{XLEN{1'b0}}, mag_a};
               end
            end
         end
         CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d  = DONE;
               result_d = final_res;
            end
         end
         FAST: begin
            result_d = acc_q[XLEN-1:0];
            state_d  = DONE;
         end
         DONE: begin
            if (mdu_if.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A flush also blocks a coincident output handshake.
      if (mdu_if.flush)
         state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         mag_b_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         mag_b_q  <= mag_b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign mdu_if.in_ready  = (state_q == IDLE);
   assign mdu_if.out_valid = (state_q == DONE);
   assign mdu_if.busy      = (state_q != IDLE);
   assign mdu_if.result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): arithmetic, latency, corner cases,
// backpressure, flush and asynchronous reset.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mdu_if (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one op, measures accept-to-out_valid latency, checks result, completes handshake.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int n;
      @(negedge clk);
      bus.funct3   = f3;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
      chk({tag, "_res"}, 64'(bus.result), 64'(exp_res));
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] held;
      logic        seen;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.funct3    = 3'b000;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outv", 64'(bus.out_valid), 64'd0);
      chk("rst_res", 64'(bus.result), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_inrdy", 64'(bus.in_ready), 64'd1);

      run_op("mul_7x6",     F3_MUL,    32'd7,        32'd6,        32'd42,       33);
      run_op("divu_100_7",  F3_DIVU,   32'd100,      32'd7,        32'd14,       33);
      run_op("remu_100_7",  F3_REMU,   32'd100,      32'd7,        32'd2,        33);
      run_op("mulhu_ff",    F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("mulh_ff",     F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
      run_op("mulhsu_ff_2", F3_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
      run_op("div_m7_2",    F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem_m7_2",    F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("div_7_m2",    F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
      run_op("rem_7_m2",    F3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
      run_op("div_5_0",     F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2);
      run_op("remu_5_0",    F3_REMU,   32'd5,        32'd0,        32'd5,        2);
      run_op("div_ovf",     F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
      run_op("rem_ovf",     F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);

      // Backpressure: hold out_ready low for 5 cycles once out_valid rises.
      @(negedge clk);
      bus.funct3 = F3_MUL; bus.op_a = 32'd12345; bus.op_b = 32'd1000; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 40 && !bus.out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk("bp_outv", 64'(bus.out_valid), 64'd1);
      held = bus.result;
      chk("bp_res", 64'(held), 64'd12345000);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_res", 64'(bus.result), 64'd12345000);
         chk("bp_hold_v", 64'(bus.out_valid), 64'd1);
         chk("bp_inrdy", 64'(bus.in_ready), 64'd0);
         chk("bp_busy", 64'(bus.busy), 64'd1);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("bp_done_v", 64'(bus.out_valid), 64'd0);
      chk("bp_done_rdy", 64'(bus.in_ready), 64'd1);
      chk("bp_done_busy", 64'(bus.busy), 64'd0);

      // Flush on the 10th CALC cycle.
      @(negedge clk);
      bus.funct3 = F3_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      chk("fl_busy", 64'(bus.busy), 64'd0);
      chk("fl_inrdy", 64'(bus.in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("fl_no_outv", 64'(seen), 64'd0);

      // Flush dominates in_valid in IDLE.
      @(negedge clk);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.funct3 = F3_MUL;
      @(posedge clk);
      #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      chk("fliv_busy", 64'(bus.busy), 64'd0);
      chk("fliv_inrdy", 64'(bus.in_ready), 64'd1);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      bus.funct3 = F3_MUL; bus.op_a = 32'd5; bus.op_b = 32'd5; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_outv", 64'(bus.out_valid), 64'd0);
      chk("ar_res", 64'(bus.result), 64'd0);
      chk("ar_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("ar_no_outv", 64'(seen), 64'd0);

      run_op("mul_3x3", F3_MUL, 32'd3, 32'd3, 32'd9, 33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
